store_data_narrower: RTL
========================

// Module: store_data_narrower
// PURPOSE
//  Store-path inverse of the load sign-extenders: narrows a 32-bit register value to byte/half/word,
//  lane-aligns it by address[1:0], and generates byte enables for data memory. Sits between EX/MEM
//  and data-memory write port. Valid/ready on both sides, 1-cycle latency, full throughput (skid buffer).
// PARAMETERS
//  DATA_W   32  datapath width (only 32 supported; lane/BE logic assumes 4 byte lanes)
//  SKID_EN   1  1 = 2-entry skid buffer (in_ready independent of out_ready); 0 = single reg, in_ready = !full | out_ready
// PORTS
//  Clk          in   1   rising-edge clock
//  Rst_n        in   1   asynchronous, active-low reset
//  in_valid     in   1   request valid
//  in_ready     out  1   block can accept request this cycle
//  in_data      in   32  store source register value
//  in_addr_lo   in   2   byte address bits [1:0]
//  in_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  out_valid    out  1   aligned store valid
//  out_ready    in   1   memory accepts store
//  out_wdata    out  32  lane-aligned write data
//  out_be       out  4   byte enables (bit i = byte lane i)
//  out_misalign out  1   half at addr_lo odd, or word at addr_lo!=0, or size==11
//  out_trunc    out  1   value not representable in signed width (STORE_FIT_CHECK_EN only; else 0)
// BEHAVIOUR
//  Reset (async, Rst_n=0): out_valid=0, out_wdata=0, out_be=0, out_misalign=0, out_trunc=0, buffers empty;
//   in_ready=0 during reset, 1 on first edge after release.
//  Transfer on in_valid&in_ready; result presented on out_valid the next cycle; consumed on out_valid&out_ready.
//  out_* stable while out_valid&!out_ready; in_* are don't-care when in_valid=0.
//  Lane rules: byte -> wdata = {4{d[7:0]}}, be = 4'b0001<<a; half -> wdata = {2{d[15:0]}}, be = 4'b0011<<a;
//   word -> wdata = d, be = 4'b1111.
//  Misaligned or size==11: out_be=4'b0000, out_misalign=1, wdata as computed (not written); still handshaked.
//  Skid (SKID_EN=1): main reg + skid reg; in_ready = skid empty (registered). Accept while out stalled -> skid;
//   on drain skid moves to main. Ordering strictly FIFO; no drop, no duplicate.
//  Simultaneous accept+consume with main full, skid empty: main reloads, no bubble.
//  Both full: in_ready=0; next consume frees skid in same cycle only after registering (1 cycle).
//  Reset mid-operation: all buffered stores discarded; no partial output.
// CONFIGURATION
//  `STORE_FIT_CHECK_EN defined: out_trunc=1 when size==byte and d[31:8] != {24{d[7]}}, or size==half and
//   d[31:16] != {16{d[15]}}; word -> 0. Registered with the data (same latency). Undefined: out_trunc tied 0,
//   check logic absent. out_trunc never blocks the store or alters out_be.
// STRUCTURE
//  Package store_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, typedef store_req_t {data,addr_lo,size},
//   typedef store_rsp_t {wdata,be,misalign,trunc}, function align_store(store_req_t) -> store_rsp_t.
//  One sub-module: store_skid_buf (generic 2-entry valid/ready skid buffer, payload width parameter).
//  Top = combinational align_store on input side + store_skid_buf on output.
// TESTING
//  1 byte d=32'hFFFF_FF80 a=2 -> wdata 32'h8080_8080, be 4'b0100, misalign 0, trunc 0.
//  2 half d=32'h0001_8000 a=2 -> wdata 32'h8000_8000, be 4'b1100; trunc 1 with macro, 0 without.
//  3 word a=1 and half a=3 and size=11 -> be 4'b0000, misalign 1, handshake completes.
//  4 back-to-back 8 stores, out_ready=0 for 3 cycles mid-stream -> in_ready drops after 2 buffered,
//    all 8 delivered in order, no loss/dup; with out_ready=1 throughout, one result per cycle.
//  5 Rst_n low with 2 stores buffered -> out_valid=0 asynchronously, outputs zero, nothing emitted after release.
//  6 Randomized size/addr/data/backpressure vs. reference model of align_store; scoreboard order and values.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and lane-alignment function for the store data narrower.
// Optional signed-fit check is compiled in when STORE_FIT_CHECK_EN is defined.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  addr_lo;
    logic [1:0]  size;
  } store_req_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        misalign;
    logic        trunc;
  } store_rsp_t;

  // Misaligned and reserved sizes keep their computed wdata but never enable a lane.
  function automatic store_rsp_t align_store(store_req_t req);
    store_rsp_t rsp;
    rsp       = '0;
    rsp.wdata = req.data;
    case (req.size)
      SZ_BYTE: begin
        rsp.wdata = {4{req.data[7:0]}};
        rsp.be    = 4'b0001 << req.addr_lo;
      end
      SZ_HALF: begin
        rsp.wdata = {2{req.data[15:0]}};
        if (req.addr_lo[0]) begin
          rsp.misalign = 1'b1;
        end else begin
          rsp.be = 4'b0011 << req.addr_lo;
        end
      end
      SZ_WORD: begin
        if (req.addr_lo != 2'b00) begin
          rsp.misalign = 1'b1;
        end else begin
          rsp.be = 4'b1111;
        end
      end
      default: begin
        rsp.misalign = 1'b1;
      end
    endcase
`ifdef STORE_FIT_CHECK_EN
    case (req.size)
      SZ_BYTE: rsp.trunc = (req.data[31:8] != {24{req.data[7]}});
      SZ_HALF: rsp.trunc = (req.data[31:16] != {16{req.data[15]}});
      default: rsp.trunc = 1'b0;
    endcase
`else
    rsp.trunc = 1'b0;
`endif
    return rsp;
  endfunction

endpackage

// File: rtl/store_skid_buf.sv
// Generic valid/ready register slice: 2-entry skid buffer (SKID_EN=1) with a
// registered in_ready, or a single register with pass-through ready (SKID_EN=0).
module store_skid_buf #(
  parameter int W       = 38,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_r;
  logic [W-1:0] main_data_r;

  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;

  generate
    if (SKID_EN) begin : g_skid
      logic         skid_valid_r;
      logic [W-1:0] skid_data_r;
      logic         ready_r;
      logic         acc_s;
      logic         cons_s;

      assign in_ready = ready_r;
      assign acc_s    = in_valid & ready_r;
      assign cons_s   = main_valid_r & out_ready;

      // ready_r always tracks "skid empty"; accepts only happen while the skid is free.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid_r <= 1'b0;
          main_data_r  <= '0;
          skid_valid_r <= 1'b0;
          skid_data_r  <= '0;
          ready_r      <= 1'b0;
        end else if (skid_valid_r) begin
          if (cons_s) begin
            main_data_r  <= skid_data_r;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b1;
          end else begin
            ready_r <= 1'b0;
          end
        end else if (acc_s) begin
          if (!main_valid_r || cons_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= in_data;
            ready_r      <= 1'b1;
          end else begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= in_data;
            ready_r      <= 1'b0;
          end
        end else begin
          if (cons_s) begin
            main_valid_r <= 1'b0;
          end else begin
            main_valid_r <= main_valid_r;
          end
          ready_r <= 1'b1;
        end
      end
    end else begin : g_single
      logic en_r;
      logic acc_s;
      logic cons_s;

      assign in_ready = en_r & (~main_valid_r | out_ready);
      assign acc_s    = in_valid & in_ready;
      assign cons_s   = main_valid_r & out_ready;

      // en_r holds in_ready low until the first edge after reset release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          en_r         <= 1'b0;
          main_valid_r <= 1'b0;
          main_data_r  <= '0;
        end else begin
          en_r <= 1'b1;
          if (acc_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= in_data;
          end else if (cons_s) begin
            main_valid_r <= 1'b0;
          end else begin
            main_valid_r <= main_valid_r;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/store_data_narrower.sv
// Store-path narrower: lane-aligns byte/half/word stores and builds byte enables,
// registered through a skid buffer. Optional macro: STORE_FIT_CHECK_EN (drives out_trunc).
module store_data_narrower
  import store_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_addr_lo,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wdata,
  output logic [3:0]        out_be,
  output logic              out_misalign,
  output logic              out_trunc
);

  localparam int RSP_W = $bits(store_rsp_t);

  store_req_t req_s;
  store_rsp_t in_rsp_s;
  store_rsp_t out_rsp_s;

  assign req_s.data    = in_data;
  assign req_s.addr_lo = in_addr_lo;
  assign req_s.size    = in_size;
  assign in_rsp_s      = align_store(req_s);

  store_skid_buf #(
    .W       (RSP_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_rsp_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_rsp_s)
  );

  assign out_wdata    = out_rsp_s.wdata;
  assign out_be       = out_rsp_s.be;
  assign out_misalign = out_rsp_s.misalign;
  assign out_trunc    = out_rsp_s.trunc;

endmodule
